lut_burst_sequencer: RTL and testbench
======================================

Name: lut_burst_sequencer

Overview:
- Controller that sequences one waveform LUT generator instance into timed stimulation bursts.
- Owns the generator's enable and step-trigger inputs and watches its end-of-table flag.
- Runs a configurable number of waveform periods per burst, a configurable number of bursts, with a configurable idle gap between bursts.
- Sits between the host/middleware configuration registers and the LUT generator. The generator's internal wait count must be set ≥ 2^STEP_W so that only this block advances it.

Parameters:
- STEP_W, 12, width of step-divider config (clock cycles per LUT sample)
- PER_W, 8, width of periods-per-burst config
- BURST_W, 8, width of burst-count config
- GAP_W, 16, width of inter-burst gap config (cycles)

Ports:
- CLK_SYS  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- START  in  1  single-cycle request to begin a sequence (honoured only in IDLE)
- ABORT  in  1  single-cycle request to stop immediately
- CFG_STEP  in  STEP_W  cycles per sample; 0 is illegal
- CFG_PERIODS  in  PER_W  periods per burst; 0 is illegal
- CFG_BURSTS  in  BURST_W  bursts per sequence; 0 is illegal
- CFG_GAP  in  GAP_W  LUT_EN-low cycles between bursts; 0 is treated as 1
- LUT_END  in  1  end-of-table flag from the generator
- LUT_EN  out  1  generator enable; low also resets the generator index to 0
- LUT_TRGG  out  1  one-cycle step pulse to the generator
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse when the sequence completes normally
- CFG_ERR  out  1  one-cycle pulse when START arrives with an illegal config
- BURST_IDX  out  BURST_W  index of the current burst, 0-based

Behaviour:
- All outputs registered. Reset (async, nRST=0) forces state IDLE, all counters to 0, and all outputs to 0.
- States: IDLE, RUN, GAP, FIN.
- IDLE:
  - START with CFG_STEP, CFG_PERIODS and CFG_BURSTS all nonzero: latch all CFG_* inputs; next cycle go to RUN with LUT_EN=1 and BUSY=1.
  - START with any of those three zero: pulse CFG_ERR for 1 cycle (cycle after START), stay in IDLE.
- RUN:
  - Step counter counts 0..step-1. At step-1, LUT_TRGG=1 for one cycle and the step counter returns to 0.
  - First LUT_TRGG occurs exactly CFG_STEP cycles after LUT_EN rises.
  - Period completes when LUT_TRGG is issued while LUT_END=1; period counter increments.
  - Generator wrap semantics (first period N samples, later periods N-1) are the generator's behaviour; this block only counts LUT_END-qualified steps.
  - Last period of a burst completes and it is not the last burst: go to GAP, LUT_EN=0 the next cycle, BURST_IDX increments.
  - Last period of the last burst completes: go to FIN.
- GAP:
  - LUT_EN=0 and LUT_TRGG=0 for max(CFG_GAP,1) cycles.
  - Then return to RUN with LUT_EN=1; step and period counters cleared, so each burst starts at sample 0.
- FIN: one cycle with DONE=1, LUT_EN=0, BUSY=1; then IDLE (BUSY=0, BURST_IDX cleared).
- ABORT, any state: next cycle IDLE, LUT_EN=0, LUT_TRGG=0, all counters cleared, no DONE.
  - ABORT has priority over START and over completion in the same cycle.
- START while BUSY: ignored, no CFG_ERR. CFG_* changes while BUSY have no effect, because the config is latched.
- Counter widths: step counter STEP_W, period counter PER_W, burst counter BURST_W, gap counter GAP_W. No counter ever wraps, because the comparisons terminate first.
- Async reset mid-burst: LUT_EN drops combinationally with reset, and the generator restarts from 0 on the next sequence.

Decomposition:
- Package lut_seq_pkg: state enum (IDLE, RUN, GAP, FIN) and the default width constants.
- Sub-module lut_seq_step_div: step prescaler (enable, load, terminal-count pulse) reused for the step and gap timing; instantiated twice.
- Main FSM stays in lut_burst_sequencer.

Test Plan:
- Nominal: generator LUT_WIDTH=8, CFG_STEP=4, CFG_PERIODS=2, CFG_BURSTS=1, START at cycle 10.
  - LUT_EN rises at 11, first LUT_TRGG at 15.
  - 15 LUT_TRGG pulses total (8+7), spaced 4 cycles apart.
  - DONE one cycle after the last LUT_TRGG, then BUSY=0.
- Multi-burst: CFG_BURSTS=3, CFG_GAP=20, CFG_PERIODS=1, CFG_STEP=2.
  - Two gaps of exactly 20 LUT_EN-low cycles.
  - BURST_IDX steps 0→1→2; generator output restarts at sample 0 after each gap; a single DONE.
- Zero gap: CFG_GAP=0 gives exactly 1 LUT_EN-low cycle between bursts.
- Illegal config: START with CFG_STEP=0 gives CFG_ERR high for 1 cycle; LUT_EN, BUSY and DONE stay 0.
- ABORT mid-RUN, asserted the same cycle as START and again during GAP: IDLE next cycle, LUT_EN=0, no DONE. A new START then runs a full nominal sequence.
- Async reset pulse mid-RUN: all outputs 0 immediately. START while BUSY is ignored (trigger count unchanged from the nominal case).

Source files
------------

// File: rtl/lut_seq_pkg.sv
// rtl/lut_seq_pkg.sv - shared state encoding and default widths for the LUT burst sequencer
package lut_seq_pkg;

  localparam int DEF_STEP_W  = 12;
  localparam int DEF_PER_W   = 8;
  localparam int DEF_BURST_W = 8;
  localparam int DEF_GAP_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/lut_seq_step_div.sv
// rtl/lut_seq_step_div.sv - cycle prescaler counting 0..term_i, used for step and gap timing
module lut_seq_step_div #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // load_i restarts from zero and masks the terminal count in the same cycle
  assign tc_o = en_i && !load_i && (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lut_burst_sequencer.sv
// rtl/lut_burst_sequencer.sv - sequences a LUT waveform generator into timed bursts separated by idle gaps
module lut_burst_sequencer
  import lut_seq_pkg::*;
#(
  parameter int STEP_W  = DEF_STEP_W,
  parameter int PER_W   = DEF_PER_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic               CLK_SYS,
  input  logic               nRST,
  input  logic               START,
  input  logic               ABORT,
  input  logic [STEP_W-1:0]  CFG_STEP,
  input  logic [PER_W-1:0]   CFG_PERIODS,
  input  logic [BURST_W-1:0] CFG_BURSTS,
  input  logic [GAP_W-1:0]   CFG_GAP,
  input  logic               LUT_END,
  output logic               LUT_EN,
  output logic               LUT_TRGG,
  output logic               BUSY,
  output logic               DONE,
  output logic               CFG_ERR,
  output logic [BURST_W-1:0] BURST_IDX
);

  seq_state_e state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d, step_term;
  logic [PER_W-1:0]   per_q, per_d, period_q, period_d;
  logic [BURST_W-1:0] bursts_q, bursts_d, burst_q, burst_d;
  logic [GAP_W-1:0]   gap_q, gap_d, gap_term;
  logic en_q, trig_q, trig_d, busy_q, done_q, err_q, err_d;
  logic en_d, busy_d, done_d;
  logic cfg_ok, last_period, last_burst, run_active, gap_active, step_tc, gap_tc;

  assign cfg_ok      = (CFG_STEP != '0) && (CFG_PERIODS != '0) && (CFG_BURSTS != '0);
  assign last_period = (period_q == per_q - PER_W'(1));
  assign last_burst  = (burst_q == bursts_q - BURST_W'(1));
  assign step_term   = step_q - STEP_W'(1);
  assign gap_term    = (gap_q == '0) ? '0 : gap_q - GAP_W'(1);
  assign run_active  = (state_q == ST_RUN);
  assign gap_active  = (state_q == ST_GAP);

  lut_seq_step_div #(.W(STEP_W)) u_step_div (
    .clk_i  (CLK_SYS),
    .rst_ni (nRST),
    .en_i   (run_active),
    .load_i (ABORT || !run_active),
    .term_i (step_term),
    .tc_o   (step_tc)
  );

  lut_seq_step_div #(.W(GAP_W)) u_gap_div (
    .clk_i  (CLK_SYS),
    .rst_ni (nRST),
    .en_i   (gap_active),
    .load_i (ABORT || !gap_active),
    .term_i (gap_term),
    .tc_o   (gap_tc)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    per_d    = per_q;
    bursts_d = bursts_q;
    gap_d    = gap_q;
    period_d = period_q;
    burst_d  = burst_q;
    trig_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        period_d = '0;
        burst_d  = '0;
        if (START && !ABORT) begin
          if (cfg_ok) begin
            step_d   = CFG_STEP;
            per_d    = CFG_PERIODS;
            bursts_d = CFG_BURSTS;
            gap_d    = CFG_GAP;
            state_d  = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // a period ends on the step pulse issued while the generator sits on its last entry
        if (trig_q && LUT_END) begin
          if (last_period) begin
            period_d = '0;
            if (last_burst) begin
              state_d = ST_FIN;
            end else begin
              state_d = ST_GAP;
              burst_d = burst_q + BURST_W'(1);
            end
          end else begin
            period_d = period_q + PER_W'(1);
          end
        end
        trig_d = step_tc && (state_d == ST_RUN);
      end
      ST_GAP: begin
        if (gap_tc) begin
          state_d = ST_RUN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        burst_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (ABORT) begin
      state_d  = ST_IDLE;
      period_d = '0;
      burst_d  = '0;
      trig_d   = 1'b0;
    end
  end

  assign en_d   = (state_d == ST_RUN);
  assign busy_d = (state_d != ST_IDLE);
  assign done_d = (state_d == ST_FIN);

  always_ff @(posedge CLK_SYS or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      per_q    <= '0;
      bursts_q <= '0;
      gap_q    <= '0;
      period_q <= '0;
      burst_q  <= '0;
      en_q     <= 1'b0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      per_q    <= per_d;
      bursts_q <= bursts_d;
      gap_q    <= gap_d;
      period_q <= period_d;
      burst_q  <= burst_d;
      en_q     <= en_d;
      trig_q   <= trig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign LUT_EN    = en_q;
  assign LUT_TRGG  = trig_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CFG_ERR   = err_q;
  assign BURST_IDX = burst_q;

endmodule

// File: tb/tb_lut_burst_sequencer.sv
// tb/tb_lut_burst_sequencer.sv - scoreboard bench for lut_burst_sequencer with an 8-entry generator model
module tb_lut_burst_sequencer;

  localparam int STEP_W  = 12;
  localparam int PER_W   = 8;
  localparam int BURST_W = 8;
  localparam int GAP_W   = 16;
  localparam int LUT_N   = 8;

  logic               CLK_SYS = 1'b0;
  logic               nRST = 1'b0;
  logic               START = 1'b0;
  logic               ABORT = 1'b0;
  logic [STEP_W-1:0]  CFG_STEP = '0;
  logic [PER_W-1:0]   CFG_PERIODS = '0;
  logic [BURST_W-1:0] CFG_BURSTS = '0;
  logic [GAP_W-1:0]   CFG_GAP = '0;
  logic               LUT_END;
  logic               LUT_EN, LUT_TRGG, BUSY, DONE, CFG_ERR;
  logic [BURST_W-1:0] BURST_IDX;

  typedef struct packed {
    int cyc;
    int val;
  } ev_t;

  ev_t trig_q[$], en_q[$], busy_q[$], done_q[$], err_q[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  gen_idx = 0;
  bit  en_prev = 1'b0;
  bit  busy_prev = 1'b0;
  int  mon_n;
  ev_t mon_e;
  int  s;

  lut_burst_sequencer #(
    .STEP_W(STEP_W), .PER_W(PER_W), .BURST_W(BURST_W), .GAP_W(GAP_W)
  ) dut (
    .CLK_SYS(CLK_SYS), .nRST(nRST), .START(START), .ABORT(ABORT),
    .CFG_STEP(CFG_STEP), .CFG_PERIODS(CFG_PERIODS), .CFG_BURSTS(CFG_BURSTS), .CFG_GAP(CFG_GAP),
    .LUT_END(LUT_END), .LUT_EN(LUT_EN), .LUT_TRGG(LUT_TRGG), .BUSY(BUSY),
    .DONE(DONE), .CFG_ERR(CFG_ERR), .BURST_IDX(BURST_IDX)
  );

  always #5 CLK_SYS = ~CLK_SYS;
  always @(posedge CLK_SYS) cyc <= cyc + 1;

  // generator: first period visits 0..N-1, later periods wrap to entry 1
  always @(posedge CLK_SYS) begin
    if (!LUT_EN) gen_idx <= 0;
    else if (LUT_TRGG) gen_idx <= (gen_idx == LUT_N - 1) ? 1 : gen_idx + 1;
  end
  assign LUT_END = (gen_idx == LUT_N - 1);

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  function automatic bit keep(input int c, input int abort_at);
    return (abort_at < 0) || (c <= abort_at);
  endfunction

  function automatic int pending();
    return trig_q.size() + en_q.size() + busy_q.size() + done_q.size() + err_q.size();
  endfunction

  task automatic take(input string tag, input int have, input ev_t e, input int val);
    if (have == 0) begin
      check_eq({tag, "_unexpected"}, cyc, -1);
    end else begin
      check_eq({tag, "_cycle"}, cyc, e.cyc);
      check_eq({tag, "_value"}, val, e.val);
    end
  endtask

  always @(negedge CLK_SYS) begin
    if (nRST) begin
      if (LUT_TRGG) begin
        mon_n = trig_q.size();
        mon_e = (mon_n > 0) ? trig_q[0] : mk(0, 0);
        if (mon_n > 0) void'(trig_q.pop_front());
        take("trig", mon_n, mon_e, int'(BURST_IDX));
      end
      if (LUT_EN != en_prev) begin
        mon_n = en_q.size();
        mon_e = (mon_n > 0) ? en_q[0] : mk(0, 0);
        if (mon_n > 0) void'(en_q.pop_front());
        take("lut_en", mon_n, mon_e, int'(LUT_EN));
      end
      if (BUSY != busy_prev) begin
        mon_n = busy_q.size();
        mon_e = (mon_n > 0) ? busy_q[0] : mk(0, 0);
        if (mon_n > 0) void'(busy_q.pop_front());
        take("busy", mon_n, mon_e, int'(BUSY));
      end
      if (DONE) begin
        mon_n = done_q.size();
        mon_e = (mon_n > 0) ? done_q[0] : mk(0, 0);
        if (mon_n > 0) void'(done_q.pop_front());
        take("done", mon_n, mon_e, int'(BURST_IDX));
      end
      if (CFG_ERR) begin
        mon_n = err_q.size();
        mon_e = (mon_n > 0) ? err_q[0] : mk(0, 0);
        if (mon_n > 0) void'(err_q.pop_front());
        take("cfg_err", mon_n, mon_e, 1);
      end
    end
    en_prev   = LUT_EN;
    busy_prev = BUSY;
  end

  // expected event timeline for a legal START sampled at the end of cycle s
  task automatic push_seq(input int st, input int step, input int per, input int bur,
                          input int gap, input int abort_at);
    int r, cnt, last, c;
    bit en_lvl, busy_lvl;
    en_lvl = 1'b0;
    busy_lvl = 1'b0;
    r = st + 1;
    if (keep(r, abort_at)) begin busy_q.push_back(mk(r, 1)); busy_lvl = 1'b1; end
    for (int b = 0; b < bur; b++) begin
      if (keep(r, abort_at)) begin en_q.push_back(mk(r, 1)); en_lvl = 1'b1; end
      cnt = LUT_N + (per - 1) * (LUT_N - 1);
      for (int k = 1; k <= cnt; k++) begin
        c = r + step * k;
        if (keep(c, abort_at)) trig_q.push_back(mk(c, b));
      end
      last = r + step * cnt;
      if (keep(last + 1, abort_at)) begin en_q.push_back(mk(last + 1, 0)); en_lvl = 1'b0; end
      if (b == bur - 1) begin
        if (keep(last + 1, abort_at)) done_q.push_back(mk(last + 1, bur - 1));
        if (keep(last + 2, abort_at)) begin busy_q.push_back(mk(last + 2, 0)); busy_lvl = 1'b0; end
      end else begin
        r = last + ((gap == 0) ? 1 : gap) + 1;
      end
    end
    if (abort_at >= 0) begin
      if (en_lvl) en_q.push_back(mk(abort_at + 1, 0));
      if (busy_lvl) busy_q.push_back(mk(abort_at + 1, 0));
    end
  endtask

  // abort_off: <0 none, 0 with START, >0 that many cycles after START
  task automatic start_seq(input int step, input int per, input int bur, input int gap,
                           input int abort_off, output int st);
    @(negedge CLK_SYS);
    st = cyc;
    CFG_STEP    = STEP_W'(step);
    CFG_PERIODS = PER_W'(per);
    CFG_BURSTS  = BURST_W'(bur);
    CFG_GAP     = GAP_W'(gap);
    START = 1'b1;
    ABORT = (abort_off == 0);
    if (step == 0 || per == 0 || bur == 0) begin
      if (abort_off != 0) err_q.push_back(mk(st + 1, 1));
    end else begin
      push_seq(st, step, per, bur, gap, (abort_off < 0) ? -1 : st + abort_off);
    end
    @(negedge CLK_SYS);
    START = 1'b0;
    ABORT = 1'b0;
    if (abort_off > 0) begin
      while (cyc < st + abort_off) @(negedge CLK_SYS);
      ABORT = 1'b1;
      @(negedge CLK_SYS);
      ABORT = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (pending() == 0 && !BUSY) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK_SYS);
    end
    repeat (6) @(negedge CLK_SYS);
    check_eq({tag, "_drained"}, ok ? pending() : -1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge CLK_SYS);
    check_eq("rst_lut_en", int'(LUT_EN), 0);
    check_eq("rst_trgg", int'(LUT_TRGG), 0);
    check_eq("rst_busy", int'(BUSY), 0);
    check_eq("rst_done", int'(DONE), 0);
    check_eq("rst_cfg_err", int'(CFG_ERR), 0);
    check_eq("rst_burst_idx", int'(BURST_IDX), 0);
    @(negedge CLK_SYS);
    nRST = 1'b1;
    while (cyc < 9) @(negedge CLK_SYS);

    start_seq(4, 2, 1, 5, -1, s);
    check_eq("nominal_start_cycle", s, 10);
    check_eq("nominal_en_at_11", int'(LUT_EN), 1);
    wait_drain("nominal");

    start_seq(2, 1, 3, 20, -1, s);
    wait_drain("multi_burst");

    start_seq(3, 1, 2, 0, -1, s);
    wait_drain("zero_gap");

    for (int i = 0; i < 3; i++) begin
      start_seq((i == 0) ? 0 : 3, (i == 1) ? 0 : 2, (i == 2) ? 0 : 1, 4, -1, s);
      check_eq("illegal_lut_en", int'(LUT_EN), 0);
      check_eq("illegal_busy", int'(BUSY), 0);
      check_eq("illegal_done", int'(DONE), 0);
      wait_drain("illegal");
    end

    start_seq(4, 2, 1, 5, 0, s);
    check_eq("abort_start_busy", int'(BUSY), 0);
    check_eq("abort_start_err", int'(CFG_ERR), 0);
    wait_drain("abort_with_start");

    start_seq(4, 2, 1, 5, 20, s);
    check_eq("abort_run_lut_en", int'(LUT_EN), 0);
    check_eq("abort_run_busy", int'(BUSY), 0);
    wait_drain("abort_run");

    start_seq(2, 1, 3, 20, 25, s);
    check_eq("abort_gap_burst_idx", int'(BURST_IDX), 0);
    check_eq("abort_gap_busy", int'(BUSY), 0);
    wait_drain("abort_gap");

    start_seq(4, 2, 1, 5, -1, s);
    while (cyc < s + 30) @(negedge CLK_SYS);
    CFG_STEP    = STEP_W'(1);
    CFG_PERIODS = PER_W'(9);
    CFG_BURSTS  = BURST_W'(4);
    START = 1'b1;
    @(negedge CLK_SYS);
    START = 1'b0;
    wait_drain("start_while_busy");

    start_seq(4, 2, 1, 5, -1, s);
    while (cyc < s + 22) @(negedge CLK_SYS);
    #1 nRST = 1'b0;
    #1;
    check_eq("async_rst_lut_en", int'(LUT_EN), 0);
    check_eq("async_rst_trgg", int'(LUT_TRGG), 0);
    check_eq("async_rst_busy", int'(BUSY), 0);
    check_eq("async_rst_done", int'(DONE), 0);
    check_eq("async_rst_burst_idx", int'(BURST_IDX), 0);
    trig_q.delete();
    en_q.delete();
    busy_q.delete();
    done_q.delete();
    err_q.delete();
    repeat (3) @(negedge CLK_SYS);
    nRST = 1'b1;
    start_seq(4, 2, 1, 5, -1, s);
    wait_drain("after_async_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
